ctrl_pipe: RTL and testbench

Pipelined control unit for the 5-stage RISC-V core. It decodes the ID-stage opcode and carries the control bundle through the ID/EX, EX/MEM and MEM/WB registers. It detects load-use hazards and generates a configurable-length stall, and it applies branch/jump flush bubbles. It sits beside the datapath pipeline registers and replaces the per-stage control plumbing in the top level.

---
 rtl/ctrl_pipe.sv | 201 ++++++++++++++++++++
 tb/tb_ctrl_pipe.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe.sv
// Pipelined control unit: ID decode, ID/EX, EX/MEM and MEM/WB control registers, load-use stall and flush bubbles.
// Optional jump/upper-immediate decode is enabled by defining CTRL_JUMP_EN.
module ctrl_pipe #(
    parameter int REG_ADDR_W      = 5,
    parameter int LOAD_USE_STALLS = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [6:0]            opcode_id,
    input  logic [REG_ADDR_W-1:0] rs1_id,
    input  logic [REG_ADDR_W-1:0] rs2_id,
    input  logic [REG_ADDR_W-1:0] rd_id,
    input  logic                  flush_i,
    output logic                  stall_o,
    output logic                  illegal_o,
    output logic                  ex_alusrc,
    output logic                  ex_branch,
    output logic                  ex_memread,
    output logic                  ex_memwrite,
    output logic                  ex_memtoreg,
    output logic                  ex_regwrite,
    output logic [1:0]            ex_aluop,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  ex_jal,
    output logic                  ex_jalr,
    output logic                  ex_lui,
    output logic                  ex_auipc,
    output logic                  mem_memread,
    output logic                  mem_memwrite,
    output logic                  mem_memtoreg,
    output logic                  mem_regwrite,
    output logic [REG_ADDR_W-1:0] mem_rd,
    output logic                  wb_memtoreg,
    output logic                  wb_regwrite,
    output logic                  wb_link,
    output logic [REG_ADDR_W-1:0] wb_rd
);

    logic                  d_legal, d_alusrc, d_branch, d_memread, d_memwrite, d_memtoreg, d_regwrite;
    logic [1:0]            d_aluop;
    logic                  rs1_used, rs2_used, hz, bubble;
    logic [1:0]            scnt_reg;

    logic                  ex_alusrc_reg, ex_branch_reg, ex_memread_reg, ex_memwrite_reg;
    logic                  ex_memtoreg_reg, ex_regwrite_reg;
    logic [1:0]            ex_aluop_reg;
    logic [REG_ADDR_W-1:0] ex_rd_reg, mem_rd_reg, wb_rd_reg;
    logic                  mem_memread_reg, mem_memwrite_reg, mem_memtoreg_reg, mem_regwrite_reg;
    logic                  wb_memtoreg_reg, wb_regwrite_reg;
`ifdef CTRL_JUMP_EN
    logic                  d_jal, d_jalr, d_lui, d_auipc, d_link;
    logic                  ex_jal_reg, ex_jalr_reg, ex_lui_reg, ex_auipc_reg, ex_link_reg;
    logic                  mem_link_reg, wb_link_reg;
`endif

    // Decoded bundle is all-zero unless a real, decodable instruction is present.
    always_comb begin
        d_legal    = 1'b0;
        d_alusrc   = 1'b0;
        d_branch   = 1'b0;
        d_memread  = 1'b0;
        d_memwrite = 1'b0;
        d_memtoreg = 1'b0;
        d_regwrite = 1'b0;
        d_aluop    = 2'b00;
        rs1_used   = 1'b0;
        rs2_used   = 1'b0;
`ifdef CTRL_JUMP_EN
        d_jal      = 1'b0;
        d_jalr     = 1'b0;
        d_lui      = 1'b0;
        d_auipc    = 1'b0;
        d_link     = 1'b0;
`endif
        if (id_valid) begin
            case (opcode_id)
                7'b0110011: begin d_legal = 1'b1; d_regwrite = 1'b1; d_aluop = 2'b10;
                                  rs1_used = 1'b1; rs2_used = 1'b1; end
                7'b0010011: begin d_legal = 1'b1; d_alusrc = 1'b1; d_regwrite = 1'b1;
                                  d_aluop = 2'b11; rs1_used = 1'b1; end
                7'b0000011: begin d_legal = 1'b1; d_alusrc = 1'b1; d_memread = 1'b1;
                                  d_memtoreg = 1'b1; d_regwrite = 1'b1; rs1_used = 1'b1; end
                7'b0100011: begin d_legal = 1'b1; d_alusrc = 1'b1; d_memwrite = 1'b1;
                                  rs1_used = 1'b1; rs2_used = 1'b1; end
                7'b1100011: begin d_legal = 1'b1; d_branch = 1'b1; d_aluop = 2'b01;
                                  rs1_used = 1'b1; rs2_used = 1'b1; end
`ifdef CTRL_JUMP_EN
                7'b1101111: begin d_legal = 1'b1; d_jal = 1'b1; d_regwrite = 1'b1; d_link = 1'b1; end
                7'b1100111: begin d_legal = 1'b1; d_jalr = 1'b1; d_alusrc = 1'b1; d_regwrite = 1'b1;
                                  d_link = 1'b1; rs1_used = 1'b1; end
                7'b0110111: begin d_legal = 1'b1; d_lui = 1'b1; d_alusrc = 1'b1; d_regwrite = 1'b1; end
                7'b0010111: begin d_legal = 1'b1; d_auipc = 1'b1; d_alusrc = 1'b1; d_regwrite = 1'b1; end
`endif
                default: ;
            endcase
        end
    end

    assign illegal_o = id_valid & ~d_legal;
    assign hz = id_valid & ex_memread_reg & (ex_rd_reg != '0) &
                ((rs1_used & (ex_rd_reg == rs1_id)) | (rs2_used & (ex_rd_reg == rs2_id)));
    assign stall_o = ~flush_i & ((scnt_reg != 2'd0) | hz);
    assign bubble  = flush_i | (scnt_reg != 2'd0) | hz;

    always_ff @(posedge clk) begin
        if (reset) begin
            scnt_reg         <= 2'd0;
            ex_alusrc_reg    <= 1'b0;
            ex_branch_reg    <= 1'b0;
            ex_memread_reg   <= 1'b0;
            ex_memwrite_reg  <= 1'b0;
            ex_memtoreg_reg  <= 1'b0;
            ex_regwrite_reg  <= 1'b0;
            ex_aluop_reg     <= 2'b00;
            ex_rd_reg        <= '0;
            mem_memread_reg  <= 1'b0;
            mem_memwrite_reg <= 1'b0;
            mem_memtoreg_reg <= 1'b0;
            mem_regwrite_reg <= 1'b0;
            mem_rd_reg       <= '0;
            wb_memtoreg_reg  <= 1'b0;
            wb_regwrite_reg  <= 1'b0;
            wb_rd_reg        <= '0;
`ifdef CTRL_JUMP_EN
            ex_jal_reg       <= 1'b0;
            ex_jalr_reg      <= 1'b0;
            ex_lui_reg       <= 1'b0;
            ex_auipc_reg     <= 1'b0;
            ex_link_reg      <= 1'b0;
            mem_link_reg     <= 1'b0;
            wb_link_reg      <= 1'b0;
`endif
        end else begin
            if (flush_i)
                scnt_reg <= 2'd0;
            else if (scnt_reg != 2'd0)
                scnt_reg <= scnt_reg - 2'd1;
            else if (hz)
                scnt_reg <= 2'(LOAD_USE_STALLS - 1);

            ex_alusrc_reg    <= ~bubble & d_alusrc;
            ex_branch_reg    <= ~bubble & d_branch;
            ex_memread_reg   <= ~bubble & d_memread;
            ex_memwrite_reg  <= ~bubble & d_memwrite;
            ex_memtoreg_reg  <= ~bubble & d_memtoreg;
            ex_regwrite_reg  <= ~bubble & d_regwrite;
            ex_aluop_reg     <= bubble ? 2'b00 : d_aluop;
            ex_rd_reg        <= (bubble | ~d_legal) ? '0 : rd_id;
            // MEM and WB always advance; stalls only bubble EX.
            mem_memread_reg  <= ex_memread_reg;
            mem_memwrite_reg <= ex_memwrite_reg;
            mem_memtoreg_reg <= ex_memtoreg_reg;
            mem_regwrite_reg <= ex_regwrite_reg;
            mem_rd_reg       <= ex_rd_reg;
            wb_memtoreg_reg  <= mem_memtoreg_reg;
            wb_regwrite_reg  <= mem_regwrite_reg;
            wb_rd_reg        <= mem_rd_reg;
`ifdef CTRL_JUMP_EN
            ex_jal_reg       <= ~bubble & d_jal;
            ex_jalr_reg      <= ~bubble & d_jalr;
            ex_lui_reg       <= ~bubble & d_lui;
            ex_auipc_reg     <= ~bubble & d_auipc;
            ex_link_reg      <= ~bubble & d_link;
            mem_link_reg     <= ex_link_reg;
            wb_link_reg      <= mem_link_reg;
`endif
        end
    end

    assign ex_alusrc    = ex_alusrc_reg;
    assign ex_branch    = ex_branch_reg;
    assign ex_memread   = ex_memread_reg;
    assign ex_memwrite  = ex_memwrite_reg;
    assign ex_memtoreg  = ex_memtoreg_reg;
    assign ex_regwrite  = ex_regwrite_reg;
    assign ex_aluop     = ex_aluop_reg;
    assign ex_rd        = ex_rd_reg;
    assign mem_memread  = mem_memread_reg;
    assign mem_memwrite = mem_memwrite_reg;
    assign mem_memtoreg = mem_memtoreg_reg;
    assign mem_regwrite = mem_regwrite_reg;
    assign mem_rd       = mem_rd_reg;
    assign wb_memtoreg  = wb_memtoreg_reg;
    assign wb_regwrite  = wb_regwrite_reg;
    assign wb_rd        = wb_rd_reg;
`ifdef CTRL_JUMP_EN
    assign ex_jal   = ex_jal_reg;
    assign ex_jalr  = ex_jalr_reg;
    assign ex_lui   = ex_lui_reg;
    assign ex_auipc = ex_auipc_reg;
    assign wb_link  = wb_link_reg;
`else
    assign ex_jal   = 1'b0;
    assign ex_jalr  = 1'b0;
    assign ex_lui   = 1'b0;
    assign ex_auipc = 1'b0;
    assign wb_link  = 1'b0;
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: two instances (1 and 3 load-use stalls) share one stimulus stream and are
// checked every cycle against a table-driven pipeline model, plus directed literal expectations.
module tb_ctrl_pipe;

    typedef struct packed {
        logic       alusrc, branch, memread, memwrite, memtoreg, regwrite;
        logic [1:0] aluop;
        logic [4:0] rd;
        logic       jal, jalr, lui, auipc, link;
    } bundle_t;

    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LW = 7'b0000011,
                           OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       id_valid = 1'b0;
    logic [6:0] opcode_id = 7'd0;
    logic [4:0] rs1_id = 5'd0, rs2_id = 5'd0, rd_id = 5'd0;
    logic       flush_i = 1'b0;
    logic       armed = 1'b0;

    logic       stall[2], illegal[2];
    logic       ex_alusrc[2], ex_branch[2], ex_memread[2], ex_memwrite[2], ex_memtoreg[2], ex_regwrite[2];
    logic [1:0] ex_aluop[2];
    logic [4:0] ex_rd[2], mem_rd[2], wb_rd[2];
    logic       ex_jal[2], ex_jalr[2], ex_lui[2], ex_auipc[2];
    logic       mem_memread[2], mem_memwrite[2], mem_memtoreg[2], mem_regwrite[2];
    logic       wb_memtoreg[2], wb_regwrite[2], wb_link[2];
    logic [35:0] outv[2];
    logic [16:0] exv[2];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dut
            ctrl_pipe #(.REG_ADDR_W(5), .LOAD_USE_STALLS(gi == 0 ? 1 : 3)) u_dut (
                .clk(clk), .reset(reset), .id_valid(id_valid), .opcode_id(opcode_id),
                .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_id(rd_id), .flush_i(flush_i),
                .stall_o(stall[gi]), .illegal_o(illegal[gi]),
                .ex_alusrc(ex_alusrc[gi]), .ex_branch(ex_branch[gi]), .ex_memread(ex_memread[gi]),
                .ex_memwrite(ex_memwrite[gi]), .ex_memtoreg(ex_memtoreg[gi]), .ex_regwrite(ex_regwrite[gi]),
                .ex_aluop(ex_aluop[gi]), .ex_rd(ex_rd[gi]),
                .ex_jal(ex_jal[gi]), .ex_jalr(ex_jalr[gi]), .ex_lui(ex_lui[gi]), .ex_auipc(ex_auipc[gi]),
                .mem_memread(mem_memread[gi]), .mem_memwrite(mem_memwrite[gi]),
                .mem_memtoreg(mem_memtoreg[gi]), .mem_regwrite(mem_regwrite[gi]), .mem_rd(mem_rd[gi]),
                .wb_memtoreg(wb_memtoreg[gi]), .wb_regwrite(wb_regwrite[gi]), .wb_link(wb_link[gi]),
                .wb_rd(wb_rd[gi])
            );
            assign exv[gi] = {ex_alusrc[gi], ex_branch[gi], ex_memread[gi], ex_memwrite[gi],
                              ex_memtoreg[gi], ex_regwrite[gi], ex_aluop[gi], ex_rd[gi],
                              ex_jal[gi], ex_jalr[gi], ex_lui[gi], ex_auipc[gi]};
            assign outv[gi] = {stall[gi], illegal[gi], exv[gi],
                               mem_memread[gi], mem_memwrite[gi], mem_memtoreg[gi], mem_regwrite[gi], mem_rd[gi],
                               wb_memtoreg[gi], wb_regwrite[gi], wb_link[gi], wb_rd[gi]};
        end
    endgenerate

    // ---------------- behavioural model ----------------
    bundle_t m_ex[2], m_mem[2], m_wb[2];
    int      m_left[2];
    int      n_stalls[2] = '{1, 3};

    function automatic logic legal(input logic [6:0] op);
        case (op)
            OP_R, OP_I, OP_LW, OP_ST, OP_BR: return 1'b1;
`ifdef CTRL_JUMP_EN
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    function automatic bundle_t decode(input logic v, input logic [6:0] op, input logic [4:0] d);
        bundle_t b;
        b = '0;
        if (v && legal(op)) begin
            case (op)
                OP_R:     b = {6'b000001, 2'b10, d, 5'b00000};
                OP_I:     b = {6'b100001, 2'b11, d, 5'b00000};
                OP_LW:    b = {6'b101011, 2'b00, d, 5'b00000};
                OP_ST:    b = {6'b100100, 2'b00, d, 5'b00000};
                OP_BR:    b = {6'b010000, 2'b01, d, 5'b00000};
                OP_JAL:   b = {6'b000001, 2'b00, d, 5'b10001};
                OP_JALR:  b = {6'b100001, 2'b00, d, 5'b01001};
                OP_LUI:   b = {6'b100001, 2'b00, d, 5'b00100};
                OP_AUIPC: b = {6'b100001, 2'b00, d, 5'b00010};
                default:  b = '0;
            endcase
        end
        return b;
    endfunction

    function automatic logic uses_rs1(input logic [6:0] op);
`ifdef CTRL_JUMP_EN
        if (op == OP_JALR) return 1'b1;
`endif
        return op == OP_R || op == OP_I || op == OP_LW || op == OP_ST || op == OP_BR;
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        return op == OP_R || op == OP_ST || op == OP_BR;
    endfunction

    function automatic logic m_hz(input int k);
        return id_valid && m_ex[k].memread && m_ex[k].rd != 0 &&
               ((uses_rs1(opcode_id) && m_ex[k].rd == rs1_id) || (uses_rs2(opcode_id) && m_ex[k].rd == rs2_id));
    endfunction

    function automatic logic [35:0] m_out(input int k);
        logic st;
        st = !flush_i && (m_left[k] > 0 || m_hz(k));
        return {st, id_valid && !legal(opcode_id),
                m_ex[k].alusrc, m_ex[k].branch, m_ex[k].memread, m_ex[k].memwrite, m_ex[k].memtoreg,
                m_ex[k].regwrite, m_ex[k].aluop, m_ex[k].rd,
                m_ex[k].jal, m_ex[k].jalr, m_ex[k].lui, m_ex[k].auipc,
                m_mem[k].memread, m_mem[k].memwrite, m_mem[k].memtoreg, m_mem[k].regwrite, m_mem[k].rd,
                m_wb[k].memtoreg, m_wb[k].regwrite, m_wb[k].link, m_wb[k].rd};
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            bundle_t nxt_ex;
            int      nxt_left;
            nxt_left = m_left[k];
            if (flush_i) begin
                nxt_ex = '0; nxt_left = 0;
            end else if (m_left[k] > 0) begin
                nxt_ex = '0; nxt_left = m_left[k] - 1;
            end else if (m_hz(k)) begin
                nxt_ex = '0; nxt_left = n_stalls[k] - 1;
            end else begin
                nxt_ex = decode(id_valid, opcode_id, rd_id);
            end
            if (reset) begin
                m_ex[k] = '0; m_mem[k] = '0; m_wb[k] = '0; m_left[k] = 0;
            end else begin
                m_wb[k]   = m_mem[k];
                m_mem[k]  = m_ex[k];
                m_ex[k]   = nxt_ex;
                m_left[k] = nxt_left;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            for (int k = 0; k < 2; k++) begin
                logic [35:0] exp_v;
                exp_v = m_out(k);
                vectors++;
                if (outv[k] !== exp_v) begin
                    miscompares++;
                    $display("FAIL model_cmp dut%0d t=%0t actual=%h required=%h", k, $time, outv[k], exp_v);
                end
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic step(input logic v, input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] d, input logic fl, input logic rs);
        @(posedge clk);
        #1;
        id_valid = v; opcode_id = op; rs1_id = r1; rs2_id = r2; rd_id = d; flush_i = fl; reset = rs;
        #1;
    endtask

    task automatic chk(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic nop();
        step(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    endtask

    logic [6:0] base_ops[5]  = '{OP_R, OP_I, OP_LW, OP_ST, OP_BR};
    logic [1:0] base_alu[5]  = '{2'b10, 2'b11, 2'b00, 2'b00, 2'b01};
    logic [4:0] base_rs1[5]  = '{5'd1, 5'd1, 5'd2, 5'd1, 5'd4};
    logic [4:0] base_rs2[5]  = '{5'd2, 5'd0, 5'd0, 5'd2, 5'd5};

    initial begin
        int cnt1, cnt3;
        step(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
        armed = 1'b1;
        step(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
        chk("reset_outputs_dut0", int'(outv[0]), 0);
        chk("reset_outputs_dut1", int'(outv[1]), 0);

        // Base decode back-to-back, rd = index+1.
        for (int i = 0; i < 6; i++) begin
            if (i < 5) step(1'b1, base_ops[i], base_rs1[i], base_rs2[i], 5'(i + 1), 1'b0, 1'b0);
            else       nop();
            if (i > 0) chk($sformatf("base_aluop_%0d", i - 1), int'(ex_aluop[1]), int'(base_alu[i - 1]));
            if (i == 3) begin
                chk("base_wb_regwrite_R", int'(wb_regwrite[1]), 1);
                chk("base_wb_rd_R", int'(wb_rd[1]), 1);
            end
            if (i == 5) chk("base_wb_memtoreg_LW", int'(wb_memtoreg[1]), 1);
        end
        nop(); nop();

        // LW x5 then ADD x5: dut0 stalls once, dut1 three times.
        step(1'b1, OP_LW, 5'd1, 5'd0, 5'd5, 1'b0, 1'b0);
        cnt1 = 0; cnt3 = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, OP_R, 5'd5, 5'd0, 5'd8, 1'b0, 1'b0);
            cnt1 += int'(stall[0]); cnt3 += int'(stall[1]);
            if (i == 1) chk("lu1_bubble_ex", int'(exv[0]), 0);
            if (i == 2) chk("lu1_add_regwrite", int'(ex_regwrite[0]), 1);
        end
        chk("lu1_stall_cycles", cnt1, 1);
        chk("lu3_stall_cycles_add", cnt3, 3);
        nop(); nop();

        // LW x7 then BR with rs2 = x7.
        step(1'b1, OP_LW, 5'd1, 5'd0, 5'd7, 1'b0, 1'b0);
        cnt3 = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, OP_BR, 5'd3, 5'd7, 5'd0, 1'b0, 1'b0);
            cnt3 += int'(stall[1]);
            if (i == 3) chk("lu3_bubble_ex", int'(exv[1]), 0);
            if (i == 4) chk("lu3_br_branch", int'(ex_branch[1]), 1);
        end
        chk("lu3_stall_cycles_br", cnt3, 3);
        nop(); nop();

        // Load to x0 never stalls.
        step(1'b1, OP_LW, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0);
        step(1'b1, OP_R, 5'd0, 5'd0, 5'd9, 1'b0, 1'b0);
        chk("x0_no_stall", int'(stall[1]), 0);
        nop(); nop();

        // Flush during the 2nd stall cycle.
        step(1'b1, OP_LW, 5'd1, 5'd0, 5'd6, 1'b0, 1'b0);
        step(1'b1, OP_R, 5'd6, 5'd0, 5'd9, 1'b0, 1'b0);
        chk("flush_pre_stall", int'(stall[1]), 1);
        step(1'b1, OP_R, 5'd6, 5'd0, 5'd9, 1'b1, 1'b0);
        chk("flush_stall_forced_low", int'(stall[1]), 0);
        nop();
        chk("flush_ex_bubble", int'(exv[1]), 0);
        chk("flush_scnt_cleared", int'(stall[1]), 0);
        nop(); nop();

        // JAL decode.
        step(1'b1, OP_JAL, 5'd0, 5'd0, 5'd1, 1'b0, 1'b0);
`ifdef CTRL_JUMP_EN
        chk("jal_legal", int'(illegal[1]), 0);
        nop();
        chk("jal_ex_jal", int'(ex_jal[1]), 1);
        chk("jal_ex_regwrite", int'(ex_regwrite[1]), 1);
        nop(); nop();
        chk("jal_wb_link", int'(wb_link[1]), 1);
`else
        chk("jal_illegal", int'(illegal[1]), 1);
        nop();
        chk("jal_ex_bubble", int'(exv[1]), 0);
        nop(); nop();
        chk("jal_wb_link_off", int'(wb_link[1]), 0);
`endif
        nop(); nop();

        // Reset during the 2nd stall cycle.
        step(1'b1, OP_LW, 5'd1, 5'd0, 5'd9, 1'b0, 1'b0);
        step(1'b1, OP_R, 5'd9, 5'd0, 5'd3, 1'b0, 1'b0);
        step(1'b1, OP_R, 5'd9, 5'd0, 5'd3, 1'b0, 1'b1);
        nop();
        chk("rst_mid_stall_stall", int'(stall[1]), 0);
        chk("rst_mid_stall_outputs", int'(outv[1]), 0);

        // Randomized traffic, small register range to provoke hazards.
        for (int i = 0; i < 3000; i++) begin
            logic [6:0] op;
            case ($urandom_range(0, 10))
                0: op = OP_R;  1: op = OP_I;   2, 3: op = OP_LW; 4: op = OP_ST; 5: op = OP_BR;
                6: op = OP_JAL; 7: op = OP_JALR; 8: op = OP_LUI; 9: op = OP_AUIPC;
                default: op = 7'($urandom);
            endcase
            step(($urandom_range(0, 9) != 0), op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), ($urandom_range(0, 11) == 0), ($urandom_range(0, 99) == 0));
        end

        nop();
        @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
